// File: rtl/iserdes_word_aligner.sv
// Word aligner for a 1:8 ISERDES: pulses bitslip until the training pattern
// is seen N_MATCH times in a row, then forwards data and optionally monitors lock.
module iserdes_word_aligner #(
  parameter logic [7:0]  PATTERN    = 8'hF0,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned N_MATCH    = 16,
  parameter int unsigned N_SLIP_MAX = 16,
  parameter int unsigned N_ERR      = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        monitor,
  input  logic [7:0]  data_in,
  output logic        bitslip,
  output logic        locked,
  output logic        failed,
  output logic [2:0]  slip_pos,
  output logic [15:0] err_cnt,
  output logic [7:0]  data_out,
  output logic        data_valid
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] MATCH_LAST  = CW'(N_MATCH - 1);
  localparam logic [CW-1:0] SLIP_MAX    = CW'(N_SLIP_MAX);
  localparam logic [CW-1:0] ERR_LAST    = CW'(N_ERR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAILED
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [CW-1:0] match_q, match_d;
  logic [CW-1:0] slip_tot_q, slip_tot_d;
  logic [CW-1:0] err_run_q, err_run_d;
  logic [2:0]    slip_pos_q, slip_pos_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic          bitslip_q, bitslip_d;
  logic          locked_q, locked_d;
  logic          failed_q, failed_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          mismatch;

  assign mismatch = (data_in != PATTERN);

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    match_d    = match_q;
    slip_tot_d = slip_tot_q;
    err_run_d  = err_run_q;
    err_cnt_d  = err_cnt_q;
    locked_d   = locked_q;
    failed_d   = failed_q;
    bitslip_d  = 1'b0;
    data_d     = data_in;
    // Track the hardware slip position from the pulse actually issued.
    slip_pos_d = slip_pos_q + 3'(bitslip_q);

    if (start) begin
      state_d    = S_SETTLE;
      settle_d   = '0;
      match_d    = '0;
      slip_tot_d = '0;
      err_run_d  = '0;
      locked_d   = 1'b0;
      failed_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d = S_CHECK;
            match_d = '0;
          end else begin
            settle_d = settle_q + CW'(1);
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            state_d   = S_SLIP;
            // Pulse is raised for the SLIP cycle itself unless the budget is spent.
            bitslip_d = (slip_tot_q != SLIP_MAX);
          end else begin
            match_d = match_q + CW'(1);
            if (match_q == MATCH_LAST) begin
              state_d  = S_LOCKED;
              locked_d = 1'b1;
            end
          end
        end
        S_SLIP: begin
          if (slip_tot_q == SLIP_MAX) begin
            state_d  = S_FAILED;
            failed_d = 1'b1;
          end else begin
            slip_tot_d = slip_tot_q + CW'(1);
            settle_d   = '0;
            state_d    = S_SETTLE;
          end
        end
        S_LOCKED: begin
          if (monitor && mismatch) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (err_run_q == ERR_LAST) begin
              err_run_d  = '0;
              locked_d   = 1'b0;
              slip_tot_d = '0;
              state_d    = S_SLIP;
              bitslip_d  = 1'b1;
            end else begin
              err_run_d = err_run_q + CW'(1);
            end
          end else begin
            err_run_d = '0;
          end
        end
        S_FAILED: ;
        default: state_d = S_IDLE;
      endcase
    end

    valid_d = locked_d;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      match_q    <= '0;
      slip_tot_q <= '0;
      err_run_q  <= '0;
      slip_pos_q <= '0;
      err_cnt_q  <= '0;
      bitslip_q  <= 1'b0;
      locked_q   <= 1'b0;
      failed_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      match_q    <= match_d;
      slip_tot_q <= slip_tot_d;
      err_run_q  <= err_run_d;
      slip_pos_q <= slip_pos_d;
      err_cnt_q  <= err_cnt_d;
      bitslip_q  <= bitslip_d;
      locked_q   <= locked_d;
      failed_q   <= failed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign locked     = locked_q;
  assign failed     = failed_q;
  assign slip_pos   = slip_pos_q;
  assign err_cnt    = err_cnt_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_iserdes_word_aligner.sv
// Bench for iserdes_word_aligner: a rotating-word ISERDES model feeds the DUT,
// data_out is scoreboarded, and scenario outcomes are compared to expected counts.
module tb_iserdes_word_aligner;

  localparam logic [7:0] PAT    = 8'hF0;
  localparam int         SETTLE = 4;
  localparam int         NSLIP  = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst, start, monitor;
  logic [7:0]  data_in;
  logic        bitslip, locked, failed, data_valid;
  logic [2:0]  slip_pos;
  logic [15:0] err_cnt;
  logic [7:0]  data_out;

  iserdes_word_aligner dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .monitor   (monitor),
    .data_in   (data_in),
    .bitslip   (bitslip),
    .locked    (locked),
    .failed    (failed),
    .slip_pos  (slip_pos),
    .err_cnt   (err_cnt),
    .data_out  (data_out),
    .data_valid(data_valid)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum int {M_ROT, M_FIX, M_RAND} mode_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] script_q[$];
  mode_t      mode;
  logic [7:0] raw, fixval;
  int         cyc = 0, hw_slips = 0, pulses = 0, last_slip = 0;
  bit         have_last = 0;
  int         exp_err = 0;

  function automatic logic [7:0] ror8(logic [7:0] x, int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < (n % 8); i++) y = {y[0], y[7:1]};
    return y;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ISERDES model: word phase follows the number of bitslip pulses seen.
  always @(negedge sys_clk) begin
    logic [7:0] w;
    if (script_q.size() > 0) w = script_q.pop_front();
    else begin
      case (mode)
        M_ROT:   w = ror8(raw, hw_slips);
        M_FIX:   w = fixval;
        default: w = 8'($urandom);
      endcase
    end
    data_in = w;
    if (!sys_rst) exp_q.push_back(w);
  end

  // Monitor: data_out scoreboard, bitslip counting and pulse spacing.
  always @(posedge sys_clk) begin
    #1;
    cyc++;
    if (sys_rst) begin
      exp_q.delete();
      hw_slips  = 0;
      have_last = 0;
    end else begin
      if (exp_q.size() > 0) check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      if (bitslip) begin
        if (have_last) begin
          total++;
          if (cyc - last_slip < SETTLE + 1) begin
            bad++;
            $display("FAIL slip_gap actual=%0d required>=%0d", cyc - last_slip, SETTLE + 1);
          end
        end
        have_last = 1;
        last_slip = cyc;
        hw_slips++;
        pulses++;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // sel: 0=locked 1=failed 2=bitslip
  task automatic wait_sig(string name, int sel, int maxc);
    logic cur;
    for (int i = 0; i < maxc; i++) begin
      step(1);
      cur = (sel == 0) ? locked : (sel == 1) ? failed : bitslip;
      if (cur) begin
        total++;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_%s actual=timeout required=high within %0d cycles", name, maxc);
  endtask

  initial begin
    int p0, unlocked;
    logic [7:0] w;
    sys_rst = 1'b1; start = 1'b0; monitor = 1'b0;
    mode = M_ROT; raw = 8'hC3; fixval = 8'h00;
    step(2);
    check("rst_bitslip", 32'(bitslip), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_failed", 32'(failed), 0);
    check("rst_slip_pos", 32'(slip_pos), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_data_valid", 32'(data_valid), 0);
    @(posedge sys_clk); #3 sys_rst = 1'b0;
    step(1);

    // Lock after two slips: C3 -> E1 -> F0
    p0 = pulses;
    pulse_start();
    wait_sig("lock1", 0, 300);
    check("s1_pulses", 32'(pulses - p0), 2);
    check("s1_slip_pos", 32'(slip_pos), 2);
    check("s1_valid", 32'(data_valid), 1);
    check("s1_failed", 32'(failed), 0);

    // Random data with monitor off must not disturb lock
    mode = M_RAND; monitor = 1'b0; p0 = pulses; unlocked = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (!locked) unlocked++;
    end
    check("s4_unlocked_cycles", 32'(unlocked), 0);
    check("s4_err_cnt", 32'(err_cnt), 32'(exp_err));
    check("s4_pulses", 32'(pulses - p0), 0);
    mode = M_FIX; fixval = PAT;
    step(3);

    // Monitoring: 3 errors then a match keeps lock; 4 in a row drops it
    monitor = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom);
      if (w == PAT) w = w ^ 8'h01;
      script_q.push_back(w);
      exp_err++;
    end
    script_q.push_back(PAT);
    step(8);
    check("s3_locked_held", 32'(locked), 1);
    check("s3_err_cnt3", 32'(err_cnt), 32'(exp_err));
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      if (w == PAT) w = w ^ 8'h80;
      script_q.push_back(w);
      exp_err++;
    end
    wait_sig("loss_slip", 2, 12);
    check("s3_unlocked", 32'(locked), 0);
    check("s3_valid_low", 32'(data_valid), 0);
    check("s3_err_cnt7", 32'(err_cnt), 32'(exp_err));
    step(40);
    check("s3_one_pulse", 32'(pulses - p0), 1);
    check("s3_relocked", 32'(locked), 1);
    check("s3_slip_pos", 32'(slip_pos), 3);
    monitor = 1'b0;

    // Failure after the slip budget, from a fresh reset
    sys_rst = 1'b1;
    step(2);
    sys_rst = 1'b0;
    check("s2_rst_slip_pos", 32'(slip_pos), 0);
    check("s2_rst_err_cnt", 32'(err_cnt), 0);
    fixval = 8'h00;
    p0 = pulses;
    pulse_start();
    wait_sig("failed", 1, 400);
    check("s2_pulses", 32'(pulses - p0), NSLIP);
    check("s2_locked", 32'(locked), 0);
    check("s2_slip_pos", 32'(slip_pos), 0);
    step(50);
    check("s2_no_more_pulses", 32'(pulses - p0), NSLIP);
    check("s2_failed_held", 32'(failed), 1);

    // Restart in the middle of CHECK after one slip
    p0 = pulses;
    pulse_start();
    check("s5_failed_cleared", 32'(failed), 0);
    wait_sig("s5_first_slip", 2, 40);
    fixval = PAT;
    step(8);
    check("s5_slip_pos_pre", 32'(slip_pos), 1);
    fixval = 8'h00;
    p0 = pulses;
    pulse_start();
    check("s5_slip_pos_kept", 32'(slip_pos), 1);
    check("s5_locked", 32'(locked), 0);
    wait_sig("s5_failed", 1, 400);
    check("s5_pulses", 32'(pulses - p0), NSLIP);
    check("s5_slip_pos_end", 32'(slip_pos), 1);

    // Asynchronous reset during a bitslip cycle
    pulse_start();
    wait_sig("s6_slip", 2, 40);
    #1 sys_rst = 1'b1;
    #1;
    check("s6_async_bitslip", 32'(bitslip), 0);
    check("s6_async_locked", 32'(locked), 0);
    check("s6_async_failed", 32'(failed), 0);
    check("s6_async_slip_pos", 32'(slip_pos), 0);
    @(posedge sys_clk); #3 sys_rst = 1'b0;
    p0 = pulses;
    step(20);
    check("s6_idle_pulses", 32'(pulses - p0), 0);
    check("s6_idle_locked", 32'(locked), 0);
    check("s6_idle_failed", 32'(failed), 0);
    check("s6_idle_slip_pos", 32'(slip_pos), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
